store_issue_ctrl: RTL and testbench
===================================

// Module: store_issue_ctrl
// PURPOSE
//  Sequences one store at a time from the LSU onto the data-memory write port.
//  Places store data and byte strobes at the byte lane given by the address.
//  Splits a store that crosses a DATA_WIDTH/8-byte boundary into two aligned beats.
//  Sits between the LSU store stage and the memory interface.
//  Reports completion, with a bus error flag, back to the LSU.
// PARAMETERS
//  DATA_WIDTH  64            bus/data width in bits; only 32 and 64 are legal
//  ADDR_WIDTH  64            address width in bits
//  OFF_WIDTH   DATA_WIDTH/32 byte offset is addr[OFF_WIDTH:0]
// PORTS
//  clk           in   1             clock, rising edge
//  rst_n         in   1             asynchronous reset, active low
//  req_valid     in   1             store request valid
//  req_ready     out  1             controller can accept a request
//  req_addr      in   ADDR_WIDTH    byte address of the store
//  req_data      in   DATA_WIDTH    store data, right-aligned (LSB = first byte)
//  req_size      in   2             store size: 0=B, 1=H, 2=W, 3=D (3 is illegal when DATA_WIDTH=32)
//  mem_valid     out  1             write beat valid
//  mem_ready     in   1             memory accepts the beat
//  mem_addr      out  ADDR_WIDTH    beat address, aligned down to DATA_WIDTH/8 bytes
//  mem_wdata     out  DATA_WIDTH    lane-shifted write data
//  mem_wstrb     out  DATA_WIDTH/8  byte strobes
//  mem_bvalid    in   1             write response valid
//  mem_bready    out  1             controller accepts the response
//  mem_berr      in   1             write response error
//  st_resp_valid out  1             store complete
//  st_resp_ready in   1             LSU takes the completion
//  st_resp_err   out  1             an error occurred on any beat
// BEHAVIOUR
//  Reset and encodings
//  - rst_n low (async): FSM goes to IDLE; all outputs 0 except req_ready=1; captured request cleared.
//  - Reset may assert in any state. The in-flight store is dropped with no completion.
//  - B=BYTES=DATA_WIDTH/8; off=addr[OFF_WIDTH:0]; n=1<<req_size; mask=(1<<n)-1.
//  - split = (off+n > B).
//  FSM states: IDLE, SEND0, WAIT0, SEND1, WAIT1, RESP.
//  - IDLE: req_ready=1. On req_valid, capture addr/data/size and go to SEND0; no other output changes.
//  - SEND0: mem_valid=1, mem_addr=addr & ~(B-1).
//    Data: mem_wdata=(data<<8*off) truncated to DATA_WIDTH. Strobes: mem_wstrb=(mask<<off) truncated to B bits.
//    On mem_ready: go to WAIT0.
//  - WAIT0: mem_bready=1. On mem_bvalid: err<=mem_berr.
//    Next: SEND1 if split && !mem_berr, else RESP. An error on beat0 suppresses beat1.
//  - SEND1: mem_valid=1, mem_addr=(addr & ~(B-1))+B (wraps modulo 2^ADDR_WIDTH).
//    Data: mem_wdata=data>>8*(B-off). Strobes: mem_wstrb=mask>>(B-off).
//    On mem_ready: go to WAIT1.
//  - WAIT1: mem_bready=1. On mem_bvalid: err<=err|mem_berr, go to RESP.
//  - RESP: st_resp_valid=1, st_resp_err=err. On st_resp_ready: go to IDLE.
//  Timing and handshakes
//  - mem_valid/addr/wdata/wstrb are registered and held stable until mem_ready.
//  - mem_bvalid is ignored outside WAIT0/WAIT1.
//  - Minimum latency, unsplit store with ready/bvalid/resp_ready tied high:
//    accept at cycle 0; beat at cycle 1; resp at cycle 2; completion at cycle 3; req_ready again at cycle 4.
//  - Only one outstanding store; no new request is accepted before RESP completes.
//  - Illegal req_size: the store is treated as full-width with n=B.
// TESTING
//  1 DW=64: addr=0x1000, size=3, data=0x1122334455667788 ->
//    one beat: addr 0x1000, wdata=data, wstrb=0xFF; resp err=0.
//  2 addr=0x1005, size=0, data=0xAB ->
//    one beat: addr 0x1000, wdata=0x0000AB0000000000, wstrb=0x20.
//  3 addr=0x1006, size=2, data=0xDDCCBBAA ->
//    beat0: 0x1000, wdata=0xBBAA000000000000, wstrb=0xC0;
//    beat1: 0x1008, wdata=0xDDCC, wstrb=0x03.
//  4 Case 3 with mem_berr=1 on beat0 -> no beat1; st_resp_err=1; back to IDLE.
//  5 Backpressure: mem_ready=0 for 5 cycles, st_resp_ready=0 for 3 cycles ->
//    beat and completion held stable; req_ready=0 throughout.
//  6 rst_n pulsed low during WAIT0 of a split store ->
//    all outputs at reset values within the same cycle; no beat1; next store processed normally.

Source files
------------

// File: rtl/store_issue_ctrl.sv
// Store issue controller: sequences one LSU store onto the data-memory write port,
// lane-shifting data/strobes and splitting stores that straddle a bus-word boundary.
module store_issue_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int OFF_WIDTH  = DATA_WIDTH/32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_data_i,
  input  logic [1:0]              req_size_i,
  output logic                    mem_valid_o,
  input  logic                    mem_ready_i,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb_o,
  input  logic                    mem_bvalid_i,
  output logic                    mem_bready_o,
  input  logic                    mem_berr_i,
  output logic                    st_resp_valid_o,
  input  logic                    st_resp_ready_i,
  output logic                    st_resp_err_o
);

  localparam int B  = DATA_WIDTH/8;
  localparam int OW = OFF_WIDTH + 1;
  localparam int NW = OFF_WIDTH + 2;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(B-1);
  localparam logic [ADDR_WIDTH-1:0] BEAT_STEP  = ADDR_WIDTH'(B);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEND0 = 3'd1,
    WAIT0 = 3'd2,
    SEND1 = 3'd3,
    WAIT1 = 3'd4,
    RESP  = 3'd5
  } state_t;

  // Byte count of a store; sizes wider than the bus collapse to full width.
  function automatic logic [NW-1:0] bytes_of(input logic [1:0] size);
    logic [3:0] n;
    n = 4'd1 << size;
    if (int'(n) > B) begin
      bytes_of = NW'(B);
    end else begin
      bytes_of = NW'(n);
    end
  endfunction

  function automatic logic split_of(input logic [OW-1:0] off, input logic [1:0] size);
    split_of = (int'(off) + int'(bytes_of(size))) > B;
  endfunction

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [1:0]              size_q, size_d;
  logic                    err_q, err_d;

  logic                    req_ready_q, req_ready_d;
  logic                    mem_valid_q, mem_valid_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [B-1:0]            mem_wstrb_q, mem_wstrb_d;
  logic                    mem_bready_q, mem_bready_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    resp_err_q, resp_err_d;

  logic [OW-1:0]           off_s;
  logic [NW-1:0]           n_s;
  logic [B-1:0]            mask_s;
  logic [2*B-1:0]          strb2_s;
  logic [2*DATA_WIDTH-1:0] data2_s;
  logic [ADDR_WIDTH-1:0]   base_s;
  logic                    split_s;

  // State and captured request registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      size_q  <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      size_q  <= size_d;
      err_q   <= err_d;
    end
  end

  assign split_s = split_of(addr_q[OFF_WIDTH:0], size_q);

  // Next-state and capture logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    size_d  = size_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          data_d  = req_data_i;
          size_d  = req_size_i;
          err_d   = 1'b0;
          state_d = SEND0;
        end else begin
          state_d = IDLE;
        end
      end
      SEND0: begin
        if (mem_ready_i) begin
          state_d = WAIT0;
        end else begin
          state_d = SEND0;
        end
      end
      WAIT0: begin
        if (mem_bvalid_i) begin
          err_d   = mem_berr_i;
          state_d = (split_s && !mem_berr_i) ? SEND1 : RESP;
        end else begin
          state_d = WAIT0;
        end
      end
      SEND1: begin
        if (mem_ready_i) begin
          state_d = WAIT1;
        end else begin
          state_d = SEND1;
        end
      end
      WAIT1: begin
        if (mem_bvalid_i) begin
          err_d   = err_q | mem_berr_i;
          state_d = RESP;
        end else begin
          state_d = WAIT1;
        end
      end
      RESP: begin
        if (st_resp_ready_i) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Lane placement: the low half of the double-width shift is beat 0, the high half beat 1.
  always_comb begin
    off_s   = addr_d[OFF_WIDTH:0];
    n_s     = bytes_of(size_d);
    mask_s  = {B{1'b1}} >> (NW'(B) - n_s);
    strb2_s = {{B{1'b0}}, mask_s} << off_s;
    data2_s = {{DATA_WIDTH{1'b0}}, data_d} << {off_s, 3'b000};
    base_s  = addr_d & ALIGN_MASK;
  end

  // Output decode from the upcoming state so every port comes straight from a flop.
  always_comb begin
    req_ready_d  = (state_d == IDLE);
    mem_valid_d  = (state_d == SEND0) || (state_d == SEND1);
    mem_bready_d = (state_d == WAIT0) || (state_d == WAIT1);
    resp_valid_d = (state_d == RESP);
    resp_err_d   = (state_d == RESP) ? err_d : 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    mem_wstrb_d  = '0;
    case (state_d)
      SEND0: begin
        mem_addr_d  = base_s;
        mem_wdata_d = data2_s[DATA_WIDTH-1:0];
        mem_wstrb_d = strb2_s[B-1:0];
      end
      SEND1: begin
        mem_addr_d  = base_s + BEAT_STEP;
        mem_wdata_d = data2_s[2*DATA_WIDTH-1:DATA_WIDTH];
        mem_wstrb_d = strb2_s[2*B-1:B];
      end
      default: begin
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        mem_wstrb_d = '0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_ready_q  <= 1'b1;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
      mem_bready_q <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      req_ready_q  <= req_ready_d;
      mem_valid_q  <= mem_valid_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      mem_bready_q <= mem_bready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready_o     = req_ready_q;
  assign mem_valid_o     = mem_valid_q;
  assign mem_addr_o      = mem_addr_q;
  assign mem_wdata_o     = mem_wdata_q;
  assign mem_wstrb_o     = mem_wstrb_q;
  assign mem_bready_o    = mem_bready_q;
  assign st_resp_valid_o = resp_valid_q;
  assign st_resp_err_o   = resp_err_q;

endmodule

// File: tb/tb_store_issue_ctrl.sv
// Randomized bench for store_issue_ctrl: a byte-placement / handshake-level model
// predicts every output each cycle, plus directed boundary and reset cases.
module tb_store_issue_ctrl;

  localparam int B = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [63:0] req_addr, req_data;
  logic [1:0]  req_size;
  logic        mem_valid, mem_ready;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_bvalid, mem_bready, mem_berr;
  logic        st_resp_valid, st_resp_ready, st_resp_err;

  always #5 clk = ~clk;

  store_issue_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_data_i(req_data), .req_size_i(req_size),
    .mem_valid_o(mem_valid), .mem_ready_i(mem_ready),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb),
    .mem_bvalid_i(mem_bvalid), .mem_bready_o(mem_bready), .mem_berr_i(mem_berr),
    .st_resp_valid_o(st_resp_valid), .st_resp_ready_i(st_resp_ready),
    .st_resp_err_o(st_resp_err)
  );

  typedef struct { logic [63:0] addr; logic [63:0] wdata; logic [7:0] wstrb; } beat_t;
  typedef struct { logic [63:0] addr; logic [63:0] data; logic [1:0] size; } req_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: a store is a list of beats still to be written, then a completion.
  bit    m_busy, m_await, m_resp;
  logic  m_err;
  beat_t m_q[$];
  req_t  dq[$];

  int p_req, p_ready, p_bval, p_berr, p_resp;
  int dut_beats, last_beats;
  logic last_err;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit roll(input int pct);
    return $urandom_range(99) < pct;
  endfunction

  // Place each data byte at its absolute lane; bytes past the word go to the next word.
  task automatic model_beats(input logic [63:0] a, input logic [63:0] d, input logic [1:0] sz,
                             output int nb, output beat_t b0, output beat_t b1);
    int off, n, p;
    off = int'(a[2:0]);
    n   = 1 << sz;
    if (n > B) n = B;
    b0.addr  = a - 64'(off);
    b1.addr  = b0.addr + 64'(B);
    b0.wdata = '0; b0.wstrb = '0;
    b1.wdata = '0; b1.wstrb = '0;
    for (int i = 0; i < B; i++) begin
      p = off + i;
      if (p < B) begin
        b0.wdata[8*p +: 8] = d[8*i +: 8];
        if (i < n) b0.wstrb[p] = 1'b1;
      end else begin
        b1.wdata[8*(p-B) +: 8] = d[8*i +: 8];
        if (i < n) b1.wstrb[p-B] = 1'b1;
      end
    end
    nb = (off + n > B) ? 2 : 1;
  endtask

  task automatic check_outputs();
    bit ev;
    ev = m_busy && !m_await && !m_resp;
    chk("req_ready", 64'(req_ready), 64'(!m_busy));
    chk("mem_valid", 64'(mem_valid), 64'(ev));
    chk("mem_bready", 64'(mem_bready), 64'(m_await));
    chk("st_resp_valid", 64'(st_resp_valid), 64'(m_resp));
    if (ev && m_q.size() > 0) begin
      chk("mem_addr", mem_addr, m_q[0].addr);
      chk("mem_wdata", mem_wdata, m_q[0].wdata);
      chk("mem_wstrb", 64'(mem_wstrb), 64'(m_q[0].wstrb));
    end
    if (m_resp) chk("st_resp_err", 64'(st_resp_err), 64'(m_err));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    chk({tag, "_mem_valid"}, 64'(mem_valid), 64'd0);
    chk({tag, "_mem_addr"}, mem_addr, 64'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 64'd0);
    chk({tag, "_mem_wstrb"}, 64'(mem_wstrb), 64'd0);
    chk({tag, "_mem_bready"}, 64'(mem_bready), 64'd0);
    chk({tag, "_resp_valid"}, 64'(st_resp_valid), 64'd0);
    chk({tag, "_resp_err"}, 64'(st_resp_err), 64'd0);
  endtask

  // One clock: check, drive the next inputs, advance the model by the coming edge's handshakes.
  task automatic cycle();
    req_t  r;
    int    nb;
    beat_t b0, b1;
    @(negedge clk);
    check_outputs();
    if (dq.size() > 0) begin
      r = dq[0];
      req_valid = 1'b1;
    end else begin
      r.addr = {$urandom, $urandom};
      r.data = {$urandom, $urandom};
      r.size = 2'($urandom_range(3));
      req_valid = roll(p_req);
    end
    req_addr      = r.addr;
    req_data      = r.data;
    req_size      = r.size;
    mem_ready     = roll(p_ready);
    mem_bvalid    = roll(p_bval);
    mem_berr      = roll(p_berr);
    st_resp_ready = roll(p_resp);
    if (mem_valid && mem_ready) dut_beats++;
    if (st_resp_valid && st_resp_ready) begin
      last_err   = st_resp_err;
      last_beats = dut_beats;
      dut_beats  = 0;
    end
    if (!m_busy) begin
      if (req_valid) begin
        model_beats(r.addr, r.data, r.size, nb, b0, b1);
        m_q.push_back(b0);
        if (nb == 2) m_q.push_back(b1);
        m_busy = 1'b1;
        m_err  = 1'b0;
        if (dq.size() > 0) void'(dq.pop_front());
      end
    end else if (m_resp) begin
      if (st_resp_ready) begin
        m_busy = 1'b0;
        m_resp = 1'b0;
      end
    end else if (m_await) begin
      if (mem_bvalid) begin
        m_await = 1'b0;
        m_err   = m_err | mem_berr;
        void'(m_q.pop_front());
        if (mem_berr) m_q.delete();
        if (m_q.size() == 0) m_resp = 1'b1;
      end
    end else if (mem_ready) begin
      m_await = 1'b1;
    end
  endtask

  task automatic run_idle(input int budget);
    int k = 0;
    while ((m_busy || dq.size() > 0) && k < budget) begin
      cycle();
      k++;
    end
    if (m_busy || dq.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: still busy after %0d cycles, required idle", budget);
    end
  endtask

  task automatic push_req(input logic [63:0] a, input logic [63:0] d, input logic [1:0] s);
    req_t r;
    r.addr = a; r.data = d; r.size = s;
    dq.push_back(r);
  endtask

  task automatic set_knobs(input int rq, input int rd, input int bv, input int be, input int rs);
    p_req = rq; p_ready = rd; p_bval = bv; p_berr = be; p_resp = rs;
  endtask

  initial begin : main
    int    nb, k;
    beat_t b0, b1;
    rst_n = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = 2'd0;
    mem_ready = 1'b0; mem_bvalid = 1'b0; mem_berr = 1'b0; st_resp_ready = 1'b0;
    m_busy = 1'b0; m_await = 1'b0; m_resp = 1'b0; m_err = 1'b0;
    dut_beats = 0; last_beats = 0; last_err = 1'b0;
    set_knobs(0, 100, 100, 0, 100);

    // Hand-computed beats pin the model.
    model_beats(64'h1006, 64'hDDCCBBAA, 2'd2, nb, b0, b1);
    chk("pin3_nb", 64'(nb), 64'd2);
    chk("pin3_b0_wdata", b0.wdata, 64'hBBAA000000000000);
    chk("pin3_b0_wstrb", 64'(b0.wstrb), 64'hC0);
    chk("pin3_b1_addr", b1.addr, 64'h1008);
    chk("pin3_b1_wdata", b1.wdata, 64'hDDCC);
    chk("pin3_b1_wstrb", 64'(b1.wstrb), 64'h03);
    model_beats(64'h1005, 64'hAB, 2'd0, nb, b0, b1);
    chk("pin2_nb", 64'(nb), 64'd1);
    chk("pin2_b0_addr", b0.addr, 64'h1000);
    chk("pin2_b0_wdata", b0.wdata, 64'h0000AB0000000000);
    chk("pin2_b0_wstrb", 64'(b0.wstrb), 64'h20);
    model_beats(64'hFFFF_FFFF_FFFF_FFFD, 64'h1, 2'd2, nb, b0, b1);
    chk("pinwrap_b1_addr", b1.addr, 64'h0);

    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Cases 1-3 at full speed.
    push_req(64'h1000, 64'h1122334455667788, 2'd3);
    run_idle(50);
    chk("case1_beats", 64'(last_beats), 64'd1);
    chk("case1_err", 64'(last_err), 64'd0);
    push_req(64'h1005, 64'hAB, 2'd0);
    push_req(64'h1006, 64'hDDCCBBAA, 2'd2);
    run_idle(50);
    chk("case3_beats", 64'(last_beats), 64'd2);

    // Case 4: error on beat 0 suppresses beat 1.
    set_knobs(0, 100, 100, 100, 100);
    push_req(64'h1006, 64'hDDCCBBAA, 2'd2);
    run_idle(50);
    chk("case4_beats", 64'(last_beats), 64'd1);
    chk("case4_err", 64'(last_err), 64'd1);

    // Case 5: memory and LSU backpressure.
    set_knobs(0, 0, 100, 0, 0);
    push_req(64'h2000, 64'hCAFEF00DDEADBEEF, 2'd3);
    repeat (6) cycle();
    p_ready = 100;
    k = 0;
    while (!m_resp && k < 20) begin cycle(); k++; end
    repeat (3) cycle();
    p_resp = 100;
    run_idle(20);
    chk("case5_beats", 64'(last_beats), 64'd1);

    // Case 6: reset during WAIT0 of a split store.
    set_knobs(0, 100, 0, 0, 100);
    push_req(64'h1006, 64'hDDCCBBAA, 2'd2);
    k = 0;
    while (!m_await && k < 20) begin cycle(); k++; end
    @(negedge clk);
    check_outputs();
    chk("case6_beats_before_reset", 64'(dut_beats), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_values("midreset");
    m_busy = 1'b0; m_await = 1'b0; m_resp = 1'b0; m_q.delete();
    dut_beats = 0;
    req_valid = 1'b0; mem_bvalid = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    chk("case6_no_beat1", 64'(mem_valid), 64'd0);
    rst_n = 1'b1;
    set_knobs(0, 100, 100, 0, 100);
    push_req(64'h1005, 64'hAB, 2'd0);
    run_idle(50);
    chk("case6_after_beats", 64'(last_beats), 64'd1);

    // Address wrap on the second beat.
    push_req(64'hFFFF_FFFF_FFFF_FFFD, 64'h0123456789ABCDEF, 2'd2);
    run_idle(50);

    // Randomized traffic with random handshakes and errors.
    set_knobs(60, 70, 60, 15, 70);
    repeat (3000) cycle();
    p_req = 0;
    run_idle(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
